// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the serial subtractor.
//   state_t       : FSM state encoding (IDLE / RUN / DONE)
//   DEFAULT_WIDTH : default operand/result width
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_sub.sv
// One-bit full subtractor, computing a - b - bin.
// It is built from two half subtractors and an OR gate that merges
// their borrows.
//   a    : minuend bit
//   b    : subtrahend bit
//   bin  : borrow in
//   d    : difference bit
//   bout : borrow out
module full_sub (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic hs1_d;
  logic hs1_b;
  logic hs2_b;

  // First half subtractor: a - b
  assign hs1_d = a ^ b;
  assign hs1_b = ~a & b;

  // Second half subtractor: (a - b) - bin
  assign d     = hs1_d ^ bin;
  assign hs2_b = ~hs1_d & bin;

  assign bout  = hs1_b | hs2_b;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor. It processes one bit per clock, LSB first.
//   clk        : clock
//   rst        : synchronous active-high reset
//   start      : begin an operation (sampled only in IDLE)
//   a, b       : operands, captured on the accepted start edge
//   diff       : a - b mod 2^WIDTH (registered)
//   borrow_out : 1 iff a < b unsigned (registered)
//   busy       : high while in RUN
//   done       : one-cycle pulse; results valid from this cycle on
//
// state | meaning
// IDLE  | waiting for start; results held
// RUN   | one bit processed per cycle, WIDTH cycles
// DONE  | done pulse, final borrow visible; back to IDLE
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             bor_q, bor_d;
  logic             bout_q, bout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic bit_d;
  logic bit_b;

  full_sub u_full_sub (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (bor_q),
    .d    (bit_d),
    .bout (bit_b)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    bor_d   = bor_q;
    bout_d  = bout_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          res_d   = '0;
          bor_d   = 1'b0;
          bout_d  = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // The difference bit enters at the MSB. After WIDTH shifts the
        // LSB of the result sits at bit 0. A shift is used here instead
        // of a concatenation so that WIDTH=1 also works.
        res_d = (res_q >> 1) | (WIDTH'(bit_d) << (WIDTH - 1));
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        bor_d = bit_b;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          // borrow_out is registered, so it is valid in the DONE cycle.
          bout_d  = bit_b;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      bor_q   <= 1'b0;
      bout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      bor_q   <= bor_d;
      bout_q  <= bout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign diff       = res_q;
  assign borrow_out = bout_q;
  assign busy       = (state_q == RUN);
  assign done       = (state_q == DONE);

endmodule

// File: tb/tb_serial_subtractor.sv
module tb_serial_subtractor;

  localparam int W  = 8;
  localparam int W4 = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  a, b;
  logic [W-1:0]  diff;
  logic          borrow_out, busy, done;

  logic          start4;
  logic [W4-1:0] a4, b4;
  logic [W4-1:0] diff4;
  logic          borrow_out4, busy4, done4;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .diff(diff), .borrow_out(borrow_out), .busy(busy), .done(done)
  );

  serial_subtractor #(.WIDTH(W4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .diff(diff4), .borrow_out(borrow_out4), .busy(busy4), .done(done4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain modular arithmetic.
  function automatic logic [W-1:0] ref_diff(input int x, input int y, input int w);
    return W'((x - y + (1 << w)) % (1 << w));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one WIDTH=8 operation. On return the bench sits in the done
  // cycle. With hold=1, start stays high; with scramble=1, a and b get
  // random values during RUN.
  task automatic op8(input logic [W-1:0] xa, input logic [W-1:0] xb,
                     input bit hold, input bit scramble, input string tag);
    int n;
    int busy_n;
    bit overlap;
    a = xa; b = xb; start = 1'b1;
    tick();
    if (!hold) start = 1'b0;
    check({tag, "_busy_after_start"}, busy, 1);
    n = 0; busy_n = 1; overlap = 0;
    while (!done && n < 40) begin
      if (scramble) begin a = W'($urandom); b = W'($urandom); end
      tick();
      n++;
      if (busy) busy_n++;
      if (busy && done) overlap = 1;
    end
    check({tag, "_latency"}, n, W);
    check({tag, "_busy_cycles"}, busy_n, W);
    check({tag, "_busy_done_overlap"}, overlap, 0);
    check({tag, "_diff"}, diff, ref_diff(xa, xb, W));
    check({tag, "_borrow"}, borrow_out, (xa < xb) ? 1 : 0);
  endtask

  initial begin
    logic [W-1:0]  ra, rb, last_d;
    logic          last_b;
    int            n;
    bit            saw_done;

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    start4 = 1'b0; a4 = '0; b4 = '0;
    tick(); tick();
    check("rst_diff", diff, 0);
    check("rst_borrow", borrow_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    rst = 1'b0;
    tick();
    check("idle_no_start_busy", busy, 0);

    // Directed cases
    op8(8'd100, 8'd37, 0, 0, "d100_37");
    tick();
    check("done_single_cycle", done, 0);
    check("hold_diff", diff, 63);
    check("hold_borrow", borrow_out, 0);
    tick(); tick();
    check("hold_diff_later", diff, 63);
    op8(8'd5, 8'd10, 0, 0, "d5_10");
    tick();
    op8(8'd0, 8'd1, 0, 0, "d0_1");
    tick();
    op8(8'd255, 8'd255, 0, 0, "d255_255");
    tick();

    // Random cases
    for (int i = 0; i < 20; i++) begin
      ra = W'($urandom); rb = W'($urandom);
      op8(ra, rb, 0, 0, "rand");
      tick();
    end

    // start held high, operands scrambled during RUN
    ra = W'($urandom); rb = W'($urandom);
    op8(ra, rb, 1, 1, "hold1");
    tick();
    check("hold_idle_after_done", busy, 0);
    check("hold_idle_no_done", done, 0);
    ra = W'($urandom); rb = W'($urandom);
    op8(ra, rb, 1, 1, "hold2");
    start = 1'b0;
    tick();

    // Reset during the 4th RUN cycle
    a = 8'd200; b = 8'd17; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_diff", diff, 0);
    check("abort_borrow", borrow_out, 0);
    saw_done = 0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) saw_done = 1;
      tick();
    end
    check("abort_no_activity", saw_done, 0);
    op8(8'd17, 8'd200, 0, 0, "after_rst");
    tick();

    // Exhaustive WIDTH=4
    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        a4 = W4'(x); b4 = W4'(y); start4 = 1'b1;
        tick();
        start4 = 1'b0;
        n = 0;
        while (!done4 && n < 20) begin
          tick();
          n++;
        end
        last_d = W'(diff4);
        last_b = borrow_out4;
        check("w4_latency", n, W4);
        check("w4_diff", last_d, W'((x - y + 16) % 16));
        check("w4_borrow", last_b, (x < y) ? 1 : 0);
        tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand/result bit width; legal range 1..32.
REQ-002 SHALL have port clk  input  1  rising-edge clock, the only clock.
REQ-003 SHALL have port rst  input  1  synchronous active-high reset, sampled on clk rising edge.
REQ-004 SHALL have port start  input  1  request to begin a subtraction; sampled only in IDLE.
REQ-005 SHALL have port a  input  WIDTH  minuend; captured on the accepted start edge.
REQ-006 SHALL have port b  input  WIDTH  subtrahend; captured on the accepted start edge.
REQ-007 SHALL have port diff  output  WIDTH  result a-b modulo 2^WIDTH, registered.
REQ-008 SHALL have port borrow_out  output  1  final borrow; 1 iff a<b unsigned, registered.
REQ-009 SHALL have port busy  output  1  high while in RUN.
REQ-010 SHALL have port done  output  1  single-cycle pulse; diff/borrow_out valid from this cycle on.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-012 IDLE with start=1 at an edge SHALL load a and b into operand shift registers, clear the borrow flip-flop, clear the bit counter, clear diff and borrow_out, and go to RUN.
REQ-013 IDLE with start=0 SHALL hold all registers.
REQ-014 Each RUN cycle SHALL process one bit, LSB first: d = a0^b0^bin; bnext = (~a0&b0) | (~(a0^b0)&bin).
REQ-015 Each RUN cycle SHALL shift d into the MSB of the result register, shift both operand registers right by one, store bnext in the borrow flip-flop, and increment the counter.
REQ-016 RUN SHALL last exactly WIDTH cycles, then go to DONE, with the result register holding the full difference.
REQ-017 DONE SHALL assert done for exactly one cycle, drive borrow_out with the final borrow, and return to IDLE.
REQ-018 Latency: for start accepted at edge k, busy SHALL be high after edges k..k+WIDTH-1 and done SHALL be high after edge k+WIDTH.
REQ-019 start SHALL be ignored in RUN and DONE; a back-to-back request is accepted no earlier than the first IDLE cycle after done.
REQ-020 diff and borrow_out SHALL hold their values after done until the next accepted start or reset.
REQ-021 Wrap-around: a<b SHALL yield the two's-complement result, e.g. WIDTH=8, 0-1 gives diff=8'hFF and borrow_out=1.
REQ-022 WIDTH=1 SHALL work with a single RUN cycle.
REQ-023 The counter SHALL be clog2(WIDTH+1) bits wide and SHALL NOT wrap within one operation.
REQ-024 busy and done SHALL never be high in the same cycle.

Reset
REQ-025 When rst=1 at an edge, SHALL go to IDLE and clear all registers: diff=0, borrow_out=0, busy=0, done=0, counter=0, borrow FF=0.
REQ-026 rst SHALL take priority over start and over any RUN/DONE activity; a reset mid-operation SHALL abort it with no done pulse.

Structure
REQ-027 A shared package SHALL hold the FSM state enum (IDLE/RUN/DONE) and the default WIDTH constant.
REQ-028 The per-bit logic SHALL be one sub-module, full_sub (inputs a, b, bin; outputs d, bout), built from two half subtractors plus an OR gate.
REQ-029 The borrow flip-flop, shift registers, counter and FSM SHALL live in serial_subtractor.

Verification
REQ-030 WIDTH=8; start with a=100, b=37 -> done 8 cycles after the start edge, diff=63, borrow_out=0, busy high for 8 cycles.
REQ-031 WIDTH=8; a=5, b=10 -> diff=251, borrow_out=1; a=0, b=1 -> diff=255, borrow_out=1; a=255, b=255 -> diff=0, borrow_out=0.
REQ-032 start held high continuously across two operations -> exactly one operation per IDLE entry; inputs changed during RUN have no effect on the result.
REQ-033 rst asserted at the 4th RUN cycle -> next cycle is IDLE with all outputs 0 and no done pulse; a new start then completes correctly.
REQ-034 WIDTH=4, exhaustive check over all 256 (a,b) pairs against a reference model -> every diff and borrow_out matches.
